// File: rtl/dmem_pkg.sv
// Shared definitions for the vector data-memory arbiter.
// Ports: none (package) -- vector geometry, the derived DATA_W word/address width,
//        the vec_t word type and the arbiter ownership state encoding.
package dmem_pkg;

  localparam int VECT_SIZE = 8;                      // elements per vector word
  localparam int ELEM_SIZE = 8;                      // bits per element
  localparam int DATA_W    = ELEM_SIZE * VECT_SIZE;  // word width, also address width

  typedef logic [DATA_W-1:0] vec_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational two-way picker used when no locked owner keeps the memory.
// Ports: req[1:0] requests in, last_gnt/override arbitration history in,
//        gnt[1:0] one-hot grant out (all zero when nothing requests).
// Build option DMEM_ARB_RR_EN: round-robin on contention; otherwise fixed priority to port 0.
module dmem_arb_pick (
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       override,
  output logic [1:0] gnt
);

`ifdef DMEM_ARB_RR_EN
  // Round-robin already hands contention to the port other than last_gnt,
  // which is exactly what the post-cap fairness override asks for.
  logic unused_override;
  assign unused_override = override;
`endif

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
`ifdef DMEM_ARB_RR_EN
        gnt = last_gnt ? 2'b01 : 2'b10;
`else
        // Port 0 normally wins; after port 0 was force-released by the burst
        // cap (override set, last_gnt = 0) port 1 gets exactly one turn.
        gnt = (override && !last_gnt) ? 2'b10 : 2'b01;
`endif
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-ported vector data memory: port 0 pipeline, port 1 loader DMA.
// Ports: clk/reset (sync, active-high); per port req/we/lock/addr/wd in, gnt/rvalid/rdata out;
//        mem_we/mem_a/mem_wd to memory, mem_rd combinational read data from memory.
// Build option DMEM_ARB_RR_EN selects round-robin contention (default fixed priority, port 0 first).
module dmem_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req0,
  input  logic                       we0,
  input  logic                       lock0,
  input  logic [dmem_pkg::DATA_W-1:0] addr0,
  input  logic [dmem_pkg::DATA_W-1:0] wd0,
  input  logic                       req1,
  input  logic                       we1,
  input  logic                       lock1,
  input  logic [dmem_pkg::DATA_W-1:0] addr1,
  input  logic [dmem_pkg::DATA_W-1:0] wd1,
  output logic                       gnt0,
  output logic                       gnt1,
  output logic                       rvalid0,
  output logic                       rvalid1,
  output logic [dmem_pkg::DATA_W-1:0] rdata0,
  output logic [dmem_pkg::DATA_W-1:0] rdata1,
  output logic                       mem_we,
  output logic [dmem_pkg::DATA_W-1:0] mem_a,
  output logic [dmem_pkg::DATA_W-1:0] mem_wd,
  input  logic [dmem_pkg::DATA_W-1:0] mem_rd
);
  import dmem_pkg::*;

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  arb_state_t       state, state_n;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_n, cnt_eff;
  logic             last_gnt, last_gnt_n;
  logic             override, override_n;
  logic [1:0]       pick_gnt, gnt_v;
  logic             win;   // index of the granted port (meaningful when gnt_v != 0)
  logic             lk;

  dmem_arb_pick u_pick (
    .req      ({req1, req0}),
    .last_gnt (last_gnt),
    .override (override),
    .gnt      (pick_gnt)
  );

  // A locked owner that is still requesting keeps the memory; otherwise the
  // picker decides in the same cycle, so a dropped owner costs no idle beat.
  always_comb begin
    gnt_v = pick_gnt;
    if (state == OWN0 && req0) begin
      gnt_v = 2'b01;
    end else if (state == OWN1 && req1) begin
      gnt_v = 2'b10;
    end
    if (reset) begin
      gnt_v = 2'b00;
    end
  end

  assign gnt0 = gnt_v[0];
  assign gnt1 = gnt_v[1];
  assign win  = gnt_v[1];

  always_comb begin
    mem_we = 1'b0;
    mem_a  = '0;
    mem_wd = '0;
    if (gnt0) begin
      mem_we = we0;
      mem_a  = addr0;
      mem_wd = wd0;
    end else if (gnt1) begin
      mem_we = we1;
      mem_a  = addr1;
      mem_wd = wd1;
    end
  end

  // Beat counting belongs to the current ownership only: a grant to a port
  // that does not already own the memory starts a fresh count from zero.
  always_comb begin
    state_n    = IDLE;
    beat_cnt_n = '0;
    last_gnt_n = last_gnt;
    override_n = 1'b0;
    cnt_eff    = ((state == OWN0 && gnt0) || (state == OWN1 && gnt1)) ? beat_cnt : '0;
    lk         = win ? lock1 : lock0;
    if (gnt_v != 2'b00) begin
      if (lk && (cnt_eff < LAST_BEAT)) begin
        state_n    = win ? OWN1 : OWN0;
        beat_cnt_n = cnt_eff + 1'b1;
      end else begin
        last_gnt_n = win;
        // Still locked here means the cap forced the release: give the
        // other port one guaranteed turn on the next cycle.
        override_n = lk;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      beat_cnt <= '0;
      last_gnt <= 1'b1;
      override <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      state    <= state_n;
      beat_cnt <= beat_cnt_n;
      last_gnt <= last_gnt_n;
      override <= override_n;
      rvalid0  <= gnt0 && !we0;
      rvalid1  <= gnt1 && !we1;
      if (gnt0 && !we0) begin
        rdata0 <= mem_rd;
      end
      if (gnt1 && !we1) begin
        rdata1 <= mem_rd;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, we0 = 1'b0, lock0 = 1'b0;
  logic        req1 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
  logic [63:0] addr0 = '0, wd0 = '0, addr1 = '0, wd1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [63:0] rdata0, rdata1, mem_a, mem_wd, mem_rd;

  // memory behind the arbiter
  logic [63:0] mem [256] = '{default: '0};
  assign mem_rd = mem[mem_a[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_a[9:2]] <= mem_wd;

  dmem_arbiter #(.MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wd0(wd0),
    .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wd1(wd1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (ownership / fairness rules) ----------------
  int          m_owner = -1;  // port currently holding a lock, -1 none
  int          m_beats = 0;   // beats already taken in that ownership
  int          m_last  = 1;   // port granted at the last release
  bit          m_fair  = 0;   // one-turn guarantee for the port not released last
  logic [63:0] ref_mem [256] = '{default: '0};
  logic        m_rv [2] = '{1'b0, 1'b0};
  logic [63:0] m_rd [2] = '{64'd0, 64'd0};

  initial forever begin
    int eg, taken;
    bit lk;
    logic        e_we;
    logic [63:0] e_a, e_wd;
    @(negedge clk);
    if (reset) eg = 2;
    else if (m_owner == 0 && req0) eg = 0;
    else if (m_owner == 1 && req1) eg = 1;
    else if (req0 && req1) begin
      if (m_fair) eg = 1 - m_last;
      else begin
`ifdef DMEM_ARB_RR_EN
        eg = 1 - m_last;
`else
        eg = 0;
`endif
      end
    end
    else if (req0) eg = 0;
    else if (req1) eg = 1;
    else eg = 2;

    e_we = 1'b0; e_a = '0; e_wd = '0;
    if (eg == 0) begin e_we = we0; e_a = addr0; e_wd = wd0; end
    if (eg == 1) begin e_we = we1; e_a = addr1; e_wd = wd1; end

    chk("gnt0", {63'd0, gnt0}, {63'd0, eg == 0});
    chk("gnt1", {63'd0, gnt1}, {63'd0, eg == 1});
    chk("mem_we", {63'd0, mem_we}, {63'd0, e_we});
    chk("mem_a", mem_a, e_a);
    chk("mem_wd", mem_wd, e_wd);
    chk("rvalid0", {63'd0, rvalid0}, {63'd0, m_rv[0]});
    chk("rvalid1", {63'd0, rvalid1}, {63'd0, m_rv[1]});
    chk("rdata0", rdata0, m_rd[0]);
    chk("rdata1", rdata1, m_rd[1]);

    // advance the model to what the coming clock edge must produce
    if (reset) begin
      m_owner = -1; m_beats = 0; m_last = 1; m_fair = 0;
      m_rv[0] = 0; m_rv[1] = 0; m_rd[0] = '0; m_rd[1] = '0;
    end else begin
      m_rv[0] = 0; m_rv[1] = 0;
      m_fair = 0;
      if (eg == 2) begin
        m_owner = -1; m_beats = 0;
      end else begin
        taken = (m_owner == eg) ? m_beats + 1 : 1;
        lk = (eg == 1) ? lock1 : lock0;
        if (lk && taken < MAXB) begin
          m_owner = eg; m_beats = taken;
        end else begin
          m_owner = -1; m_beats = 0; m_last = eg; m_fair = lk;
        end
        if (e_we) ref_mem[e_a[9:2]] = e_wd;
        else begin
          m_rv[eg] = 1;
          m_rd[eg] = ref_mem[e_a[9:2]];
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  logic [63:0] nxt_a0 = 64'h10, nxt_wd0 = '0, nxt_a1 = 64'h40, nxt_wd1 = '0;

  task automatic cyc(input logic rst, input logic r0, w0, l0, input logic r1, w1, l1,
                     output int g);
    @(posedge clk); #1;
    reset = rst;
    req0 = r0; we0 = w0; lock0 = l0; addr0 = nxt_a0; wd0 = nxt_wd0;
    req1 = r1; we1 = w1; lock1 = l1; addr1 = nxt_a1; wd1 = nxt_wd1;
    @(negedge clk);
    g = gnt0 ? 0 : (gnt1 ? 1 : 2);
  endtask

  task automatic rnd_wd();
    nxt_wd0 = {$urandom, $urandom};
    nxt_wd1 = {$urandom, $urandom};
  endtask

  initial begin
    int g;
    int exp_cont [4];
    int exp_l1   [7];
    int exp_l0   [6] = '{0, 0, 0, 0, 1, 0};
    int exp_drop [8] = '{0, 0, 1, 0, 0, 0, 0, 1};
    int exp_rst  [4] = '{1, 1, 2, 0};
`ifdef DMEM_ARB_RR_EN
    exp_cont = '{0, 1, 0, 1};
    exp_l1   = '{1, 1, 1, 1, 0, 1, 1};
`else
    exp_cont = '{0, 0, 0, 0};
    exp_l1   = '{1, 1, 1, 1, 0, 0, 1};
`endif

    // reset held with a pending write on port 0
    nxt_wd0 = 64'hDEAD_BEEF_0000_0001;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 1, 0, 0, 0, 0, g);
      chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
      chk("rst_rvalid0", {63'd0, rvalid0}, 64'd0);
      chk("rst_rvalid1", {63'd0, rvalid1}, 64'd0);
      chk("rst_rdata0", rdata0, 64'd0);
      chk("rst_rdata1", rdata1, 64'd0);
    end

    // contention, both reading, no lock
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 0, 1, 0, 0, g);
      chk($sformatf("cont_beat%0d", i), 64'(g), 64'(exp_cont[i]));
    end

    // write then read back on port 0
    nxt_a0 = 64'h10; nxt_wd0 = 64'hA5A5_A5A5_A5A5_A5A5;
    cyc(0, 1, 1, 0, 0, 0, 0, g);
    chk("wr_gnt", 64'(g), 64'd0);
    nxt_wd0 = 64'h0;
    cyc(0, 1, 0, 0, 0, 0, 0, g);
    chk("rd_gnt", 64'(g), 64'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, g);
    chk("rd_rvalid", {63'd0, rvalid0}, 64'd1);
    chk("rd_rdata", rdata0, 64'hA5A5_A5A5_A5A5_A5A5);
    cyc(0, 0, 0, 0, 0, 0, 0, g);
    chk("rd_rvalid_drop", {63'd0, rvalid0}, 64'd0);
    chk("rd_rdata_hold", rdata0, 64'hA5A5_A5A5_A5A5_A5A5);

    // port 1 locked burst against a waiting port 0
    cyc(1, 0, 0, 0, 0, 0, 0, g);
    for (int i = 0; i < 7; i++) begin
      rnd_wd();
      if (i == 0)      cyc(0, 0, 0, 0, 1, 0, 1, g);
      else if (i < 6)  cyc(0, 1, 0, 0, 1, 0, 1, g);
      else             cyc(0, 0, 0, 0, 1, 0, 1, g);
      chk($sformatf("lock1_beat%0d", i), 64'(g), 64'(exp_l1[i]));
    end

    // port 0 locked burst: cap forces one turn for port 1
    cyc(1, 0, 0, 0, 0, 0, 0, g);
    for (int i = 0; i < 6; i++) begin
      rnd_wd();
      cyc(0, 1, 1, 1, 1, 1, 0, g);
      chk($sformatf("lock0_beat%0d", i), 64'(g), 64'(exp_l0[i]));
    end

    // owner drops mid-lock; next ownership counts from zero again
    cyc(1, 0, 0, 0, 0, 0, 0, g);
    for (int i = 0; i < 8; i++) begin
      rnd_wd();
      if (i == 2) cyc(0, 0, 0, 0, 1, 1, 0, g);
      else        cyc(0, 1, 0, 1, 1, 1, 0, g);
      chk($sformatf("drop_beat%0d", i), 64'(g), 64'(exp_drop[i]));
    end

    // reset in the middle of a locked port-1 write burst
    cyc(1, 0, 0, 0, 0, 0, 0, g);
    for (int i = 0; i < 4; i++) begin
      rnd_wd();
      if (i < 2)       cyc(0, 0, 0, 0, 1, 1, 1, g);
      else if (i == 2) cyc(1, 1, 1, 1, 1, 1, 1, g);
      else             cyc(0, 1, 0, 0, 1, 0, 1, g);
      chk($sformatf("rstburst_beat%0d", i), 64'(g), 64'(exp_rst[i]));
      if (i == 2) chk("rstburst_mem_we", {63'd0, mem_we}, 64'd0);
    end

    cyc(0, 0, 0, 0, 0, 0, 0, g);
    cyc(0, 0, 0, 0, 0, 0, 0, g);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
